// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arb
// Brief    : Round-robin time-sharing of one array multiplier between two
//            valid/ready clients, with registered operands and product.
// Revision : 1.0 - initial release
// ============================================================================

module multiplier_2d #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [M+N-1:0] p
);
    logic [M+N-1:0] w_a_ext;
    logic [M+N-1:0] w_acc [0:N];

    assign w_a_ext  = {{N{1'b0}}, a};
    assign w_acc[0] = '0;

    // One shifted partial-product row per bit of b, accumulated down the array.
    for (genvar j = 0; j < N; j++) begin : g_row
        assign w_acc[j+1] = w_acc[j] + (b[j] ? (w_a_ext << j) : '0);
    end

    assign p = w_acc[N];
endmodule

module mult_share_arb #(
    parameter int M      = 4,
    parameter int N      = 4,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid0,
    output logic           req_ready0,
    input  logic [M-1:0]   a0,
    input  logic [N-1:0]   b0,
    input  logic           req_valid1,
    output logic           req_ready1,
    input  logic [M-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic           res_valid0,
    input  logic           res_ready0,
    output logic           res_valid1,
    input  logic           res_ready1,
    output logic [M+N-1:0] res_data,
    output logic           busy
);
    localparam logic [3:0] c_settle_m1 = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_last_grant;
    logic           r_owner;
    logic [M-1:0]   r_op_a;
    logic [N-1:0]   r_op_b;
    logic [M+N-1:0] r_res_data;
    logic [3:0]     r_cnt;

    logic           w_idle;
    logic           w_grant0;
    logic           w_grant1;
    logic [M+N-1:0] w_prod;
    logic           w_owner_ready;

    assign w_idle = (r_state == S_IDLE);

    // On a tie the client that was not served last wins.
    assign w_grant0 = w_idle && req_valid0 && (!req_valid1 || r_last_grant);
    assign w_grant1 = w_idle && req_valid1 && (!req_valid0 || !r_last_grant);

    assign w_owner_ready = r_owner ? res_ready1 : res_ready0;

    multiplier_2d #(
        .M (M),
        .N (N)
    ) u_mult (
        .a (r_op_a),
        .b (r_op_b),
        .p (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_res_data   <= '0;
            r_cnt        <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_op_a       <= w_grant1 ? a1 : a0;
                        r_op_b       <= w_grant1 ? b1 : b0;
                        r_owner      <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_cnt        <= c_settle_m1;
                        r_state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_cnt == 4'd0) begin
                        r_res_data <= w_prod;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (w_owner_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready0 = w_grant0;
    assign req_ready1 = w_grant1;
    assign res_valid0 = (r_state == S_RESP) && !r_owner;
    assign res_valid1 = (r_state == S_RESP) &&  r_owner;
    assign res_data   = r_res_data;
    assign busy       = !w_idle;
endmodule

`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arb
// Brief    : Directed self-checking bench for mult_share_arb (M=N=4, SETTLE=2).
// Revision : 1.0 - initial release
// ============================================================================

module tb_mult_share_arb;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid0, req_valid1;
    logic       req_ready0, req_ready1;
    logic [3:0] a0, b0, a1, b1;
    logic       res_valid0, res_valid1;
    logic       res_ready0, res_ready1;
    logic [7:0] res_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mult_share_arb #(.M(4), .N(4), .SETTLE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid0 (req_valid0),
        .req_ready0 (req_ready0),
        .a0         (a0),
        .b0         (b0),
        .req_valid1 (req_valid1),
        .req_ready1 (req_ready1),
        .a1         (a1),
        .b1         (b1),
        .res_valid0 (res_valid0),
        .res_ready0 (res_ready0),
        .res_valid1 (res_valid1),
        .res_ready1 (res_ready1),
        .res_data   (res_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for res_validK; reports how many edges it took.
    task automatic wait_valid(input int k, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 20; i++) begin
            if ((k == 0) ? res_valid0 : res_valid1) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        res_ready0 = 1'b0; res_ready1 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready0, req_ready1, res_valid0, res_valid1, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {req_ready0, req_ready1, res_valid0, res_valid1, busy});
        end
        checks++;
        if (res_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00", res_data);
        end
    endtask

    task automatic test_single();
        req_valid0 = 1'b1; a0 = 4'd3; b0 = 4'd5; res_ready0 = 1'b1;
        #1;
        checks++;
        if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got r0=%b r1=%b expected r0=1 r1=0", req_ready0, req_ready1);
        end
        tick();
        req_valid0 = 1'b0;
        #1;
        checks++;
        if (req_ready0 !== 1'b0 || busy !== 1'b1 || res_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL single_calc: got r0=%b busy=%b v0=%b expected 0 1 0", req_ready0, busy, res_valid0);
        end
        tick();
        checks++;
        if (res_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got v0=%b expected 0 one edge after handshake", res_valid0);
        end
        tick();
        checks++;
        if (res_valid0 !== 1'b1 || res_valid1 !== 1'b0 || res_data !== 8'h0F) begin
            errors++;
            $display("FAIL single_result: got v0=%b v1=%b data=%h expected 1 0 0f", res_valid0, res_valid1, res_data);
        end
        tick();
        checks++;
        if (res_valid0 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got v0=%b busy=%b expected 0 0", res_valid0, busy);
        end
    endtask

    task automatic test_tie();
        bit ok;
        int n;
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
        req_valid1 = 1'b1; a1 = 4'd7;  b1 = 4'd9;
        res_ready0 = 1'b1; res_ready1 = 1'b1;
        #1;
        checks++;
        if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL tie_first: got r0=%b r1=%b expected r0=1 r1=0", req_ready0, req_ready1);
        end
        tick();
        req_valid0 = 1'b0;
        wait_valid(0, ok, n);
        checks++;
        if (!ok || n != 2 || res_data !== 8'hE1) begin
            errors++;
            $display("FAIL tie_res0: got ok=%0d edges=%0d data=%h expected 1 2 e1", ok, n, res_data);
        end
        tick();
        checks++;
        if (req_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL tie_second: got r1=%b expected 1", req_ready1);
        end
        tick();
        req_valid1 = 1'b0;
        wait_valid(1, ok, n);
        checks++;
        if (!ok || n != 2 || res_data !== 8'h3F || res_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL tie_res1: got ok=%0d edges=%0d data=%h v0=%b expected 1 2 3f 0", ok, n, res_data, res_valid0);
        end
        tick();
    endtask

    task automatic test_fairness();
        int grants [6];
        int gcyc   [6];
        int ng = 0;
        int cyc = 0;
        int bad = 0;
        // last grant was client 1, so the sequence starts with client 0
        req_valid0 = 1'b1; a0 = 4'd2; b0 = 4'd3;
        req_valid1 = 1'b1; a1 = 4'd4; b1 = 4'd5;
        res_ready0 = 1'b1; res_ready1 = 1'b1;
        #1;
        while (ng < 6 && cyc < 200) begin
            if ((req_ready0 || req_ready1) && (busy || (req_ready0 && req_ready1)))
                bad++;
            if (req_ready0 || req_ready1) begin
                grants[ng] = req_ready1 ? 1 : 0;
                gcyc[ng]   = cyc;
                ng++;
            end
            if (ng < 6) begin
                tick();
                cyc++;
            end
        end
        tick();
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        checks++;
        if (ng != 6 || bad != 0) begin
            errors++;
            $display("FAIL fair_count: got grants=%0d illegal_ready=%0d expected 6 0", ng, bad);
        end
        for (int i = 0; i < ng; i++) begin
            checks++;
            if (grants[i] != (i % 2)) begin
                errors++;
                $display("FAIL fair_order[%0d]: got client %0d expected %0d", i, grants[i], i % 2);
            end
        end
        for (int i = 1; i < ng; i++) begin
            checks++;
            if (gcyc[i] - gcyc[i-1] != 4) begin
                errors++;
                $display("FAIL fair_interval[%0d]: got %0d cycles expected 4", i, gcyc[i] - gcyc[i-1]);
            end
        end
        for (int i = 0; i < 20 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fair_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_hold();
        bit ok;
        int n;
        req_valid1 = 1'b1; a1 = 4'd7; b1 = 4'd9;
        res_ready1 = 1'b0; res_ready0 = 1'b1;
        #1;
        checks++;
        if (req_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL hold_accept: got r1=%b expected 1", req_ready1);
        end
        tick();
        req_valid1 = 1'b0;
        req_valid0 = 1'b1; a0 = 4'd2; b0 = 4'd2;
        wait_valid(1, ok, n);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_timeout: got no res_valid1 expected res_valid1 within 20 edges");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid1 !== 1'b1 || res_data !== 8'h3F || req_ready0 !== 1'b0 || res_valid0 !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got v1=%b data=%h r0=%b v0=%b expected 1 3f 0 0",
                         i, res_valid1, res_data, req_ready0, res_valid0);
            end
            tick();
        end
        res_ready1 = 1'b1;
        tick();
        checks++;
        if (res_valid1 !== 1'b0 || req_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got v1=%b r0=%b expected 0 1", res_valid1, req_ready0);
        end
        tick();
        req_valid0 = 1'b0;
        wait_valid(0, ok, n);
        checks++;
        if (!ok || res_data !== 8'h04) begin
            errors++;
            $display("FAIL hold_next: got ok=%0d data=%h expected 1 04", ok, res_data);
        end
        tick();
    endtask

    task automatic test_zero_one();
        bit ok;
        int n;
        res_ready0 = 1'b1; res_ready1 = 1'b1;
        req_valid0 = 1'b1; a0 = 4'd0; b0 = 4'd12;
        tick();
        req_valid0 = 1'b0;
        wait_valid(0, ok, n);
        checks++;
        if (!ok || res_data !== 8'h00) begin
            errors++;
            $display("FAIL zero_operand: got ok=%0d data=%h expected 1 00", ok, res_data);
        end
        tick();
        req_valid1 = 1'b1; a1 = 4'd1; b1 = 4'd15;
        tick();
        req_valid1 = 1'b0;
        a1 = 4'd15; b1 = 4'd15;
        wait_valid(1, ok, n);
        checks++;
        if (!ok || res_data !== 8'h0F) begin
            errors++;
            $display("FAIL one_operand_stable: got ok=%0d data=%h expected 1 0f", ok, res_data);
        end
        tick();
    endtask

    task automatic test_reset_calc();
        bit ok;
        int n;
        int seen = 0;
        res_ready0 = 1'b1;
        req_valid0 = 1'b1; a0 = 4'd5; b0 = 4'd5;
        tick();
        req_valid0 = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstcalc_busy: got busy=%b expected 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid0 !== 1'b0 || res_valid1 !== 1'b0 || res_data !== 8'h00) begin
            errors++;
            $display("FAIL rstcalc_state: got busy=%b v0=%b v1=%b data=%h expected 0 0 0 00",
                     busy, res_valid0, res_valid1, res_data);
        end
        for (int i = 0; i < 4; i++) begin
            if (res_valid0 || res_valid1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstcalc_discard: got %0d stray res_valid cycles expected 0", seen);
        end
        req_valid0 = 1'b1; a0 = 4'd6; b0 = 4'd7;
        tick();
        req_valid0 = 1'b0;
        wait_valid(0, ok, n);
        checks++;
        if (!ok || n != 2 || res_data !== 8'h2A) begin
            errors++;
            $display("FAIL rstcalc_after: got ok=%0d edges=%0d data=%h expected 1 2 2a", ok, n, res_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_hold();
        test_zero_one();
        test_reset_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
